// File: rtl/sha256_stream_if.sv
// Byte-stream adapter for a single-block SHA-256 core: gathers and pads a
// message, starts the core, then streams the captured digest out byte by byte.
module sha256_stream_if #(
    parameter int unsigned BLOCK_SIZE  = 512,
    parameter int unsigned DIGEST_SIZE = 256,
    parameter int unsigned MAX_BYTES   = 55
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [BLOCK_SIZE-1:0]  core_block,
    output logic                   core_start,
    input  logic                   core_done,
    input  logic [DIGEST_SIZE-1:0] core_digest,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   err
);

    typedef enum logic [2:0] {LOAD, DRAIN, PAD, START, WAIT, SEND} state_t;

    state_t                   state, state_nx;
    logic [5:0]               byte_cnt;
    logic [4:0]               out_idx;
    logic [DIGEST_SIZE-1:0]   digest;
    logic                     at_max;

    assign at_max = (byte_cnt == 6'(MAX_BYTES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = digest[{~out_idx, 3'b000} +: 8];
        case (state)
            LOAD: begin
                in_ready = !reset;
                if (in_valid) begin
                    // A last byte landing in the 56th slot is overlong: flag it and stay in LOAD
                    if (in_last)     state_nx = at_max ? LOAD : PAD;
                    else if (at_max) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                in_ready = !reset;
                if (in_valid && in_last) state_nx = LOAD;
            end
            PAD:   state_nx = START;
            START: begin
                core_start = 1'b1;
                state_nx   = WAIT;
            end
            WAIT:  if (core_done) state_nx = SEND;
            SEND: begin
                out_valid = 1'b1;
                out_last  = (out_idx == 5'd31);
                if (out_ready && out_idx == 5'd31) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_block <= '0;
            digest     <= '0;
            byte_cnt   <= '0;
            out_idx    <= '0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (!at_max) begin
                            core_block[{6'd63 - byte_cnt, 3'b000} +: 8] <= in_data;
                            byte_cnt <= byte_cnt + 6'd1;
                        end else if (in_last) begin
                            err        <= 1'b1;
                            core_block <= '0;
                            byte_cnt   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (in_valid && in_last) begin
                        err        <= 1'b1;
                        core_block <= '0;
                        byte_cnt   <= '0;
                    end
                end
                PAD: begin
                    for (int unsigned k = 0; k < 56; k++) begin
                        if (k == 32'(byte_cnt))
                            core_block[8*(63-k) +: 8] <= 8'h80;
                        else if (k > 32'(byte_cnt))
                            core_block[8*(63-k) +: 8] <= '0;
                    end
                    core_block[63:0] <= {55'd0, byte_cnt, 3'b000};
                end
                WAIT: begin
                    if (core_done) begin
                        digest  <= core_digest;
                        out_idx <= '0;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        out_idx <= out_idx + 5'd1;
                        if (out_idx == 5'd31) begin
                            core_block <= '0;
                            byte_cnt   <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sha256_stream_if.md
Name: sha256_stream_if

Overview:
- Host-side byte-stream adapter for the SHA-256 core. Sits between a byte source/sink and the core.
- Inbound path: collects a message one byte at a time, applies standard SHA-256 single-block padding, presents the 512-bit block, and pulses core start.
- Outbound path: captures the 256-bit digest and streams it out byte by byte under valid/ready.
- Messages up to 55 bytes (one block) are supported; longer messages are flagged and discarded.

Parameters:
- BLOCK_SIZE, 512, padded block width in bits; fixed for SHA-256.
- DIGEST_SIZE, 256, digest width in bits; 32 output bytes.
- MAX_BYTES, 55, longest message that fits one block with 0x80 and a 64-bit length.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  in_data is valid.
- in_data  in  8  message byte, first byte first.
- in_last  in  1  qualifies the final message byte; empty messages are not supported.
- in_ready  out  1  adapter accepts a byte this cycle.
- core_block  out  512  padded block; byte 0 at [511:504].
- core_start  out  1  one-cycle pulse; core_block is stable from this cycle until the digest is captured.
- core_done  in  1  core digest valid; sampled in WAIT only.
- core_digest  in  256  digest; byte 0 at [255:248].
- out_valid  out  1  out_data is valid.
- out_data  out  8  digest byte.
- out_last  out  1  high with digest byte 31.
- out_ready  in  1  sink accepts out_data.
- err  out  1  one-cycle pulse: message exceeded MAX_BYTES.

Behaviour:
- Reset values:
  - state = LOAD, byte_cnt = 0, out_idx = 0.
  - core_block = 0, digest register = 0.
  - in_ready = 0 during reset, then 1 in LOAD.
  - core_start, out_valid, out_last, err = 0.
- A handshake completes on a rising edge with valid && ready high.
- LOAD:
  - in_ready = 1.
  - Accepted byte is written at byte position byte_cnt (bits [511-8k:504-8k]); byte_cnt increments.
  - Accepted byte with in_last → PAD.
  - Accepted non-last byte when byte_cnt == MAX_BYTES (56th byte) → DRAIN.
  - An accepted in_last byte that is itself the 56th byte → DRAIN-exit behaviour (err pulse, return to LOAD).
- DRAIN:
  - in_ready = 1; bytes are discarded.
  - On accepted in_last: err = 1 for one cycle, buffer and byte_cnt cleared, → LOAD.
  - No core_start is ever issued for an overlong message.
- PAD (1 cycle), in_ready = 0:
  - byte[byte_cnt] = 0x80.
  - Bytes byte_cnt+1..55 = 0.
  - core_block[63:0] = byte_cnt × 8, zero-extended to 64 bits.
  - → START.
- START (1 cycle): core_start = 1 → WAIT.
- WAIT:
  - Hold core_block.
  - On core_done = 1: register core_digest, out_idx = 0 → SEND.
  - No timeout.
- SEND:
  - out_valid = 1; out_data = digest byte out_idx; out_last = (out_idx == 31).
  - On handshake, out_idx increments.
  - out_data is held stable while out_ready = 0.
  - Handshake on byte 31 → LOAD, clear core_block and byte_cnt.
- Latency:
  - Last input byte accepted at edge N → core_start high in cycle N+2.
  - core_done sampled at edge M → out_valid high in cycle M+1.
  - Minimum 32 cycles to drain the digest.
- in_ready is 0 in PAD, START, WAIT and SEND; input is accepted only in LOAD and DRAIN.
- core_done outside WAIT is ignored.
- Reset asserted mid-operation (any state) → immediate return to reset values. A partial digest stream is abandoned and not resumed.
- Width rule: byte_cnt is 6 bits, saturating logic not needed (DRAIN caps it); out_idx is 5 bits.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63):
  - core_block = 0x61626380 followed by zeros, [63:0] = 0x18; core_start two cycles after the last byte.
  - Model core returns 0xba7816bf…f20015ad; out_data streams ba,78,16,bf,…,15,ad; out_last on 0xad.
- "Hello, SHA-256!" (15 bytes, 0x48…0x21):
  - Byte 15 = 0x80; length = 0x78.
  - Digest 0xd0e8b8f1…75a46271 emitted as d0,e8,b8,…,62,71.
- 55-byte message of 0x00: byte 55 = 0x80; [63:0] = 0x1B8; no err.
- 56-byte message: err pulses once on the cycle after the 56th (last) byte is accepted; core_start never asserts; in_ready remains 1; a following "abc" hashes correctly.
- Backpressure: out_ready toggles 1,0,0,1 on a random pattern → 32 bytes in order, none duplicated or dropped, out_data stable while stalled.
- Reset asserted after 10 digest bytes in SEND → out_valid = 0 and in_ready = 1 after release; a new "abc" yields the full, correct 32-byte digest.
